// File: rtl/axi4_stream_pipeline_chain_pkg.sv
// Shared constants and width helpers for the AXI4-Stream register chain.
package axi4_stream_pipeline_pkg;

  localparam int FWD_SLICE  = 0;
  localparam int SKID_SLICE = 1;

  // Flat word = {tdata, tlast, tstrb, tkeep, tid, tdest, tuser}
  function automatic int word_width(input int tdata_w, input int tid_w,
                                    input int tdest_w, input int tuser_w);
    return tdata_w + 1 + 2 * (tdata_w / 8) + tid_w + tdest_w + tuser_w;
  endfunction

  function automatic int occ_width(input int stages, input int skid_mode);
    int w;
    w = $clog2(stages * (skid_mode + 1) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axi4_stream_pipeline_chain_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) ();
  logic                       tvalid;
  logic                       tready;
  logic [TDATA_WIDTH-1:0]     tdata;
  logic [TDATA_WIDTH/8-1:0]   tstrb;
  logic [TDATA_WIDTH/8-1:0]   tkeep;
  logic                       tlast;
  logic [TID_WIDTH-1:0]       tid;
  logic [TDEST_WIDTH-1:0]     tdest;
  logic [TUSER_WIDTH-1:0]     tuser;

  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/axi4_stream_pipeline_chain_slice.sv
// One register slice on a flat word bus: skid (2 entries, registered ready)
// or forward-only (1 entry, combinational ready).
module axi4_stream_slice
  import axi4_stream_pipeline_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int SKID_MODE = SKID_SLICE
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              up_valid,
  input  logic [WORD_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [WORD_W-1:0] dn_data,
  input  logic              dn_ready
);

  if (SKID_MODE == SKID_SLICE) begin : g_skid
    logic              valid_m, valid_s;
    logic [WORD_W-1:0] data_m, data_s;
    logic              up_hs, dn_hs;

    assign up_ready = !valid_s;
    assign up_hs    = up_valid && up_ready;
    assign dn_hs    = valid_m && dn_ready;
    assign dn_valid = valid_m;
    assign dn_data  = data_m;

    // up_ready is !valid_s, so an accepted word never finds the skid occupied
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        valid_m <= 1'b0;
        valid_s <= 1'b0;
        data_m  <= '0;
        data_s  <= '0;
      end else if (up_hs) begin
        if (!valid_m || dn_ready) begin
          valid_m <= 1'b1;
          data_m  <= up_data;
        end else begin
          valid_s <= 1'b1;
          data_s  <= up_data;
        end
      end else if (dn_hs) begin
        if (valid_s) begin
          data_m  <= data_s;
          valid_s <= 1'b0;
        end else begin
          valid_m <= 1'b0;
        end
      end
    end
  end else begin : g_fwd
    logic              valid_m;
    logic [WORD_W-1:0] data_m;
    logic              up_hs, dn_hs;

    assign up_ready = !valid_m || dn_ready;
    assign up_hs    = up_valid && up_ready;
    assign dn_hs    = valid_m && dn_ready;
    assign dn_valid = valid_m;
    assign dn_data  = data_m;

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        valid_m <= 1'b0;
        data_m  <= '0;
      end else if (up_hs) begin
        valid_m <= 1'b1;
        data_m  <= up_data;
      end else if (dn_hs) begin
        valid_m <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4_stream_pipeline_chain.sv
// STAGES-deep AXI4-Stream register chain carrying all sideband fields.
// Optional occupancy_o counter under AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN.
module axi4_stream_pipeline_chain
  import axi4_stream_pipeline_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int STAGES      = 2,
  parameter int SKID_MODE   = SKID_SLICE
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
  , output logic [occ_width(STAGES, SKID_MODE)-1:0] occupancy_o
`endif
);

  localparam int WORD_W = word_width(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);

  logic [WORD_W-1:0] word_in, word_out;

  assign word_in = {pkt_i.tdata, pkt_i.tlast, pkt_i.tstrb, pkt_i.tkeep,
                    pkt_i.tid, pkt_i.tdest, pkt_i.tuser};
  assign {pkt_o.tdata, pkt_o.tlast, pkt_o.tstrb, pkt_o.tkeep,
          pkt_o.tid, pkt_o.tdest, pkt_o.tuser} = word_out;

  if (STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_n_i;
    assign word_out       = word_in;
    assign pkt_o.tvalid   = pkt_i.tvalid;
    assign pkt_i.tready   = pkt_o.tready;
  end else begin : g_chain
    logic                         run_q;
    logic [STAGES:0]              vld;
    logic [STAGES:0][WORD_W-1:0]  data;

    // Holds the input side closed during reset, including the
    // forward-only case whose ready would otherwise be combinationally high.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) run_q <= 1'b0;
      else          run_q <= 1'b1;
    end

    assign vld[0]  = pkt_i.tvalid && run_q;
    assign data[0] = word_in;

    // Ready travels backwards through per-stage nets so the forward-only
    // chain does not form a self-referencing vector.
    for (genvar g = 0; g < STAGES; g++) begin : g_slice
      logic up_rdy, dn_rdy;
      if (g == STAGES - 1) begin : g_tail
        assign dn_rdy = pkt_o.tready;
      end else begin : g_link
        assign dn_rdy = g_slice[g+1].up_rdy;
      end

      axi4_stream_slice #(
        .WORD_W    (WORD_W),
        .SKID_MODE (SKID_MODE)
      ) u_slice (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .up_valid (vld[g]),
        .up_data  (data[g]),
        .up_ready (up_rdy),
        .dn_valid (vld[g+1]),
        .dn_data  (data[g+1]),
        .dn_ready (dn_rdy)
      );
    end

    assign pkt_i.tready = g_slice[0].up_rdy && run_q;
    assign pkt_o.tvalid = vld[STAGES];
    assign word_out     = data[STAGES];
  end

`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
  localparam int OCC_W = occ_width(STAGES, SKID_MODE);

  logic             in_hs, out_hs;
  logic [OCC_W-1:0] occ_q;

  assign in_hs  = pkt_i.tvalid && pkt_i.tready;
  assign out_hs = pkt_o.tvalid && pkt_o.tready;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)              occ_q <= '0;
    else if (in_hs && !out_hs) occ_q <= occ_q + 1'b1;
    else if (!in_hs && out_hs) occ_q <= occ_q - 1'b1;
  end

  assign occupancy_o = occ_q;
`endif

endmodule

// File: tb/tb_axi4_stream_pipeline_chain.sv
// Directed bench: four chain builds (3/2 skid, 4 forward-only, 0 pass-through).
module tb_axi4_stream_pipeline_chain;
  localparam int TDW = 32;
  localparam int SW  = TDW / 8;
  localparam int IDW = 4;
  localparam int DW  = 4;
  localparam int UW  = 4;

  typedef struct packed {
    logic [TDW-1:0] tdata;
    logic [SW-1:0]  tstrb;
    logic [SW-1:0]  tkeep;
    logic           tlast;
    logic [IDW-1:0] tid;
    logic [DW-1:0]  tdest;
    logic [UW-1:0]  tuser;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(TDW), .TID_WIDTH(IDW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW)) a3_i (), a3_o ();
  axi4_stream_if #(.TDATA_WIDTH(TDW), .TID_WIDTH(IDW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW)) a2_i (), a2_o ();
  axi4_stream_if #(.TDATA_WIDTH(TDW), .TID_WIDTH(IDW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW)) a4_i (), a4_o ();
  axi4_stream_if #(.TDATA_WIDTH(TDW), .TID_WIDTH(IDW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW)) a0_i (), a0_o ();

`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
  logic [2:0] occ3, occ2, occ4;
  logic [0:0] occ0;
`endif

  axi4_stream_pipeline_chain #(.TDATA_WIDTH(TDW), .TID_WIDTH(IDW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW),
    .STAGES(3), .SKID_MODE(1)) u_s3 (.clk_i(clk), .rst_n_i(rst_n), .pkt_i(a3_i), .pkt_o(a3_o)
`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
    , .occupancy_o(occ3)
`endif
  );
  axi4_stream_pipeline_chain #(.TDATA_WIDTH(TDW), .TID_WIDTH(IDW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW),
    .STAGES(2), .SKID_MODE(1)) u_s2 (.clk_i(clk), .rst_n_i(rst_n), .pkt_i(a2_i), .pkt_o(a2_o)
`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
    , .occupancy_o(occ2)
`endif
  );
  axi4_stream_pipeline_chain #(.TDATA_WIDTH(TDW), .TID_WIDTH(IDW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW),
    .STAGES(4), .SKID_MODE(0)) u_f4 (.clk_i(clk), .rst_n_i(rst_n), .pkt_i(a4_i), .pkt_o(a4_o)
`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
    , .occupancy_o(occ4)
`endif
  );
  axi4_stream_pipeline_chain #(.TDATA_WIDTH(TDW), .TID_WIDTH(IDW), .TDEST_WIDTH(DW), .TUSER_WIDTH(UW),
    .STAGES(0), .SKID_MODE(1)) u_p0 (.clk_i(clk), .rst_n_i(rst_n), .pkt_i(a0_i), .pkt_o(a0_o)
`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
    , .occupancy_o(occ0)
`endif
  );

  word_t o3, o2, o4, o0;
  assign o3 = {a3_o.tdata, a3_o.tstrb, a3_o.tkeep, a3_o.tlast, a3_o.tid, a3_o.tdest, a3_o.tuser};
  assign o2 = {a2_o.tdata, a2_o.tstrb, a2_o.tkeep, a2_o.tlast, a2_o.tid, a2_o.tdest, a2_o.tuser};
  assign o4 = {a4_o.tdata, a4_o.tstrb, a4_o.tkeep, a4_o.tlast, a4_o.tid, a4_o.tdest, a4_o.tuser};
  assign o0 = {a0_o.tdata, a0_o.tstrb, a0_o.tkeep, a0_o.tlast, a0_o.tid, a0_o.tdest, a0_o.tuser};

  function automatic word_t mk(input int k);
    word_t w;
    w.tdata = k;
    w.tstrb = '1;
    w.tkeep = SW'(k | 1);
    w.tlast = (k % 5 == 4);
    w.tid   = IDW'(k);
    w.tdest = DW'(k >> 2);
    w.tuser = UW'(~k);
    return w;
  endfunction

  task automatic drv3(input logic v, input word_t w);
    a3_i.tvalid = v;
    {a3_i.tdata, a3_i.tstrb, a3_i.tkeep, a3_i.tlast, a3_i.tid, a3_i.tdest, a3_i.tuser} = w;
  endtask
  task automatic drv2(input logic v, input word_t w);
    a2_i.tvalid = v;
    {a2_i.tdata, a2_i.tstrb, a2_i.tkeep, a2_i.tlast, a2_i.tid, a2_i.tdest, a2_i.tuser} = w;
  endtask
  task automatic drv4(input logic v, input word_t w);
    a4_i.tvalid = v;
    {a4_i.tdata, a4_i.tstrb, a4_i.tkeep, a4_i.tlast, a4_i.tid, a4_i.tdest, a4_i.tuser} = w;
  endtask
  task automatic drv0(input logic v, input word_t w);
    a0_i.tvalid = v;
    {a0_i.tdata, a0_i.tstrb, a0_i.tkeep, a0_i.tlast, a0_i.tid, a0_i.tdest, a0_i.tuser} = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drv3(1'b0, '0); drv2(1'b0, '0); drv4(1'b0, '0);
    a3_o.tready = 1'b1; a2_o.tready = 1'b1; a4_o.tready = 1'b1;
    drv0(1'b1, mk(7));
    a0_o.tready = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    n_chk++;
    if ({a3_o.tvalid, a2_o.tvalid, a4_o.tvalid} !== 3'b000)
      $display("FAIL reset_out_valid: got %b want 000", {a3_o.tvalid, a2_o.tvalid, a4_o.tvalid});
    else n_pass++;
    n_chk++;
    if ({a3_i.tready, a2_i.tready, a4_i.tready} !== 3'b000)
      $display("FAIL reset_in_ready: got %b want 000", {a3_i.tready, a2_i.tready, a4_i.tready});
    else n_pass++;
    n_chk++;
    if ({a0_o.tvalid, a0_i.tready, o0} !== {1'b1, 1'b0, mk(7)})
      $display("FAIL reset_passthru: got %b/%b/%h want 1/0/%h", a0_o.tvalid, a0_i.tready, o0, mk(7));
    else n_pass++;
    n_pass += 0;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (a3_i.tready !== 1'b0)
      $display("FAIL ready_before_edge: got %b want 0", a3_i.tready);
    else n_pass++;
    step();
    n_chk++;
    if ({a3_i.tready, a2_i.tready, a4_i.tready} !== 3'b111)
      $display("FAIL ready_after_release: got %b want 111", {a3_i.tready, a2_i.tready, a4_i.tready});
    else n_pass++;
  endtask

  task automatic test_passthru();
    word_t w;
    logic  v, r;
    for (int i = 0; i < 4; i++) begin
      w = mk(200 + i * 37);
      v = (i % 2 == 1);
      r = (i >= 2);
      drv0(v, w);
      a0_o.tready = r;
      #1;
      n_chk++;
      if ({a0_o.tvalid, a0_i.tready, o0} !== {v, r, w})
        $display("FAIL passthru_%0d: got %b/%b/%h want %b/%b/%h", i, a0_o.tvalid, a0_i.tready, o0, v, r, w);
      else n_pass++;
    end
    drv0(1'b0, '0);
  endtask

  task automatic test_stream();
    int rx = 0, first = -1, last = -1, stalls = 0;
    a3_o.tready = 1'b1;
    drv3(1'b0, '0);
    for (int i = 0; i < 110; i++) begin
      step();
      if (a3_o.tvalid) begin
        if (first < 0) first = i;
        last = i;
        n_chk++;
        if (o3 !== mk(rx)) $display("FAIL stream_word_%0d: got %h want %h", rx, o3, mk(rx));
        else n_pass++;
        rx++;
      end
      if (i < 100) begin
        drv3(1'b1, mk(i));
        #1;
        if (!a3_i.tready) stalls++;
      end else begin
        drv3(1'b0, '0);
      end
    end
    n_chk++;
    if (first !== 3) $display("FAIL stream_latency: got %0d want 3", first);
    else n_pass++;
    n_chk++;
    if (rx !== 100 || last !== 102) $display("FAIL stream_gapless: got %0d words ending %0d want 100 ending 102", rx, last);
    else n_pass++;
    n_chk++;
    if (stalls !== 0) $display("FAIL stream_in_ready: got %0d stalls want 0", stalls);
    else n_pass++;
  endtask

  task automatic test_stall();
    int    tx = 0, rx = 0, drop_buf = -1;
    logic  hold = 1'b0;
    word_t held = '0;
    for (int i = 0; i < 80 && rx < 20; i++) begin
      step();
      if (hold) begin
        n_chk++;
        if (o2 !== held || a2_o.tvalid !== 1'b1)
          $display("FAIL stall_hold_%0d: got %b/%h want 1/%h", i, a2_o.tvalid, o2, held);
        else n_pass++;
      end
      drv2(tx < 20, mk(tx + 300));
      a2_o.tready = !(i >= 8 && i < 13);
      #1;
      if (a2_i.tvalid && !a2_i.tready && drop_buf < 0) drop_buf = tx - rx;
      if (a2_o.tvalid && a2_o.tready) begin
        n_chk++;
        if (o2 !== mk(rx + 300)) $display("FAIL stall_word_%0d: got %h want %h", rx, o2, mk(rx + 300));
        else n_pass++;
        rx++;
      end
      hold = a2_o.tvalid && !a2_o.tready;
      held = o2;
      if (a2_i.tvalid && a2_i.tready) tx++;
    end
    n_chk++;
    if (rx !== 20) $display("FAIL stall_count: got %0d want 20", rx);
    else n_pass++;
    n_chk++;
    if (drop_buf !== 4) $display("FAIL stall_ready_drop: got %0d buffered want 4", drop_buf);
    else n_pass++;
    drv2(1'b0, '0);
    a2_o.tready = 1'b1;
    repeat (2) step();
  endtask

`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
  task automatic test_occupancy();
    n_chk++;
    if (occ2 !== 3'd0) $display("FAIL occ_start: got %0d want 0", occ2);
    else n_pass++;
    a2_o.tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv2(1'b1, mk(500 + k));
      step();
      n_chk++;
      if (occ2 !== 3'(k + 1)) $display("FAIL occ_up_%0d: got %0d want %0d", k, occ2, k + 1);
      else n_pass++;
    end
    drv2(1'b0, '0);
    a2_o.tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (o2 !== mk(500 + k)) $display("FAIL occ_word_%0d: got %h want %h", k, o2, mk(500 + k));
      else n_pass++;
      step();
      n_chk++;
      if (occ2 !== 3'(3 - k)) $display("FAIL occ_down_%0d: got %0d want %0d", k, occ2, 3 - k);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_fwd_random();
    word_t q[$];
    word_t cur = '0, exp;
    logic  v = 1'b0;
    int    tx = 0, rx = 0;
    for (int i = 0; i < 20000 && rx < 1000; i++) begin
      step();
      if (!v && tx < 1000) begin
        v = 1'($urandom_range(0, 1));
        cur.tdata = $urandom;
        cur.tstrb = SW'($urandom);
        cur.tkeep = SW'($urandom);
        cur.tlast = 1'($urandom);
        cur.tid   = IDW'($urandom);
        cur.tdest = DW'($urandom);
        cur.tuser = UW'($urandom);
      end
      drv4(v, cur);
      a4_o.tready = 1'($urandom_range(0, 1));
      #1;
      if (a4_i.tvalid && a4_i.tready) begin
        q.push_back(cur);
        tx++;
        v = 1'b0;
      end
      if (a4_o.tvalid && a4_o.tready) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL fwd_spurious: got %h want no word", o4);
        end else begin
          exp = q.pop_front();
          if (o4 !== exp) $display("FAIL fwd_word_%0d: got %h want %h", rx, o4, exp);
          else n_pass++;
        end
        rx++;
      end
    end
    n_chk++;
    if (rx !== 1000 || q.size() !== 0) $display("FAIL fwd_count: got %0d out %0d pending want 1000/0", rx, q.size());
    else n_pass++;
    drv4(1'b0, '0);
    a4_o.tready = 1'b1;
    step();
  endtask

  task automatic test_reset_midflight();
    word_t wa5;
    int    seen = 0, at = -1;
    a3_o.tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drv3(1'b1, mk(600 + k));
      step();
    end
    drv3(1'b0, '0);
    rst_n = 1'b0;
    step();
    n_chk++;
    if ({a3_o.tvalid, a3_i.tready} !== 2'b00)
      $display("FAIL midreset_idle: got %b want 00", {a3_o.tvalid, a3_i.tready});
    else n_pass++;
    rst_n = 1'b1;
    a3_o.tready = 1'b1;
    step();
    wa5 = mk(9);
    wa5.tdata = 32'h0000_00A5;
    drv3(1'b1, wa5);
    #1;
    n_chk++;
    if (a3_i.tready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", a3_i.tready);
    else n_pass++;
    step();
    drv3(1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      if (a3_o.tvalid) begin
        seen++;
        if (seen == 1) begin
          at = i;
          n_chk++;
          if (o3 !== wa5) $display("FAIL midreset_word: got %h want %h", o3, wa5);
          else n_pass++;
        end
      end
      step();
    end
    n_chk++;
    if (seen !== 1 || at !== 2) $display("FAIL midreset_stale: got %0d words first at %0d want 1 at 2", seen, at);
    else n_pass++;
  endtask

  initial begin
    drv3(1'b0, '0); drv2(1'b0, '0); drv4(1'b0, '0); drv0(1'b0, '0);
    a3_o.tready = 1'b1; a2_o.tready = 1'b1; a4_o.tready = 1'b1; a0_o.tready = 1'b1;
    test_reset();
    test_passthru();
    test_stream();
    test_stall();
`ifdef AXI4_STREAM_PIPELINE_CHAIN_OCCUPANCY_EN
    test_occupancy();
`endif
    test_fwd_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
